dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target end of the CPU's load/store interface.
- Accepts one word request at a time over a valid/ready handshake and waits a programmable number of cycles.
- Performs the read or write on an internal word array, then returns a response over a second valid/ready handshake.
- Replaces the zero-handshake DMemory so the CPU FSM can be tested against variable memory latency.

Parameters:
- DEPTH, 256, number of 32-bit words stored. Must be a power of 2, minimum 4.
- WAIT_STATES, 2, extra cycles between request accept and the array access; 0..15.
- DATA_WIDTH, 32, word width. Only 32 is supported.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; must be word-aligned.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_error  out  1  1 = misaligned or out-of-range access.
- dbg_addr  in  log2(DEPTH)  word index for the verification peek port.
- dbg_rdata  out  32  combinational read of array[dbg_addr]; has no side effects.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
- Reset does not clear the array. Array contents are X until written, or preloaded by the bench.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - If req_valid=1 at an edge: capture req_write, req_addr and req_wdata; load counter=WAIT_STATES; go to BUSY.
- BUSY:
  - req_ready=0.
  - If counter≠0: decrement the counter.
  - If counter=0: perform the access at this edge, register resp_rdata and resp_error, go to RESP.
- Latency: resp_valid rises WAIT_STATES+1 edges after the accept edge. With WAIT_STATES=0 that is the next edge.
- Access rules:
  - Error when addr[1:0]≠0 or addr[31:2] ≥ DEPTH. On error, suppress the write, set resp_rdata=0 and resp_error=1.
  - Valid store: array[addr[log2(DEPTH)+1:2]] ← wdata; resp_rdata=0.
  - Valid load: resp_rdata ← array[index], the value before any same-edge change.
- RESP:
  - resp_valid=1. resp_rdata and resp_error are held stable until resp_ready=1.
  - Edge with resp_ready=1: resp_valid←0, go to IDLE.
  - No new request is accepted in RESP. The fastest back-to-back interval is WAIT_STATES+3 edges.
- Requests asserted while req_ready=0 are ignored. The requester must hold them until it sees req_ready.
- Reset mid-operation:
  - Any in-flight request is abandoned and no response is produced.
  - If reset coincides with the BUSY counter=0 edge, reset wins and the store is not performed.
- resp_ready=1 while resp_valid=0 has no effect.
- The store is visible on dbg_rdata from the edge after the access.

Decomposition:
- Shared package cpu_mem_pkg:
  - State enum (IDLE=2'b00, BUSY=2'b01, RESP=2'b10).
  - MEM_READ=0 and MEM_WRITE=1 constants, matching the CPU's Read/Write encoding.
  - Alignment mask constant.
- One natural sub-module: dmem_array.
  - Single-port synchronous-write word array with an asynchronous read port plus a second asynchronous debug read port, parameterised by DEPTH.
  - The FSM, counter and error check stay in dmem_responder.

Test Plan:
- Reset, then store addr=0x10 wdata=0xDEADBEEF with WAIT_STATES=2:
  - Accepted on the first edge with req_valid.
  - resp_valid rises 3 edges later with resp_error=0, resp_rdata=0.
  - dbg_addr=4 then reads 0xDEADBEEF.
- Load addr=0x10 after that store, holding resp_ready=0 for 5 cycles:
  - resp_rdata=0xDEADBEEF is stable throughout with resp_valid=1.
  - Drops one edge after resp_ready=1.
  - req_ready stays 0 until the state returns to IDLE.
- Store addr=0x13 (misaligned), then store addr=DEPTH*4 (0x400):
  - Both give resp_error=1, resp_rdata=0.
  - dbg_rdata at index 4 is unchanged, still 0xDEADBEEF.
- WAIT_STATES=0, back-to-back loads with resp_ready tied to 1:
  - Responses arrive 1 edge after each accept.
  - New accepts are spaced 3 edges apart.
  - A req_valid pulse shorter than the wait for req_ready is never answered.
- Store addr=0x20 wdata=0x12345678, with reset asserted on the counter=0 edge:
  - No response; state=IDLE, req_ready=1.
  - dbg index 8 is unchanged (bench preloads 0xCAFEF00D).
- Reset asserted while in RESP:
  - resp_valid=0 on the next edge.
  - A subsequent load of index 4 returns 0xDEADBEEF, showing the array is not cleared by reset.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the CPU data-memory interface: FSM states, access
// encodings and the address error rule.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } memState_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    // Misaligned byte address, or word index beyond the array.
    function automatic logic addrError(input logic [31:0] addr, input int depth);
        return ((addr & ALIGN_MASK) != 32'h0) || (32'(addr[31:2]) >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the CPU and data memory.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Word array: synchronous write, asynchronous read, plus an independent
// asynchronous peek port that never disturbs the access port.
module dmem_array #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata,
    input  logic [$clog2(DEPTH)-1:0] dbgAddr,
    output logic [DATA_WIDTH-1:0]    dbgRdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata    = mem[addr];
    assign dbgRdata = mem[dbgAddr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles,
// accesses the array and holds the response until the requester takes it.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | request captured, counting down wait states
// RESP  | response presented, waiting for resp_ready
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    dmem_responder_if.slave          bus,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_rdata
);
    localparam int AW = $clog2(DEPTH);

    memState_t             state, stateNext;
    logic [3:0]            count, countNext;
    logic                  capWrite;
    logic [31:0]           capAddr;
    logic [DATA_WIDTH-1:0] capWdata;
    logic [DATA_WIDTH-1:0] respRdata;
    logic                  respError;
    logic                  accept, access, accErr, wrEn;
    logic [DATA_WIDTH-1:0] arrRdata;

    assign accErr = addrError(capAddr, DEPTH);
    // The array has no reset, so a reset on the access edge must veto the write.
    assign wrEn   = access && (capWrite == MEM_WRITE) && !accErr && !reset;

    dmem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .wrEn     (wrEn),
        .addr     (capAddr[AW+1:2]),
        .wdata    (capWdata),
        .rdata    (arrRdata),
        .dbgAddr  (dbg_addr),
        .dbgRdata (dbg_rdata)
    );

    always_comb begin
        stateNext = state;
        countNext = count;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    countNext = 4'(WAIT_STATES);
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (count != 4'd0) begin
                    countNext = count - 4'd1;
                end else begin
                    access    = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            capWrite  <= MEM_READ;
            capAddr   <= 32'h0;
            capWdata  <= '0;
            respRdata <= '0;
            respError <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (accept) begin
                capWrite <= bus.req_write;
                capAddr  <= bus.req_addr;
                capWdata <= bus.req_wdata;
            end
            if (access) begin
                respError <= accErr;
                respRdata <= (accErr || capWrite == MEM_WRITE) ? '0 : arrRdata;
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = respRdata;
    assign bus.resp_error = respError;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench: instance A (DEPTH=256, 2 wait states) and
// instance B (DEPTH=4, no wait states).
module tb_dmem_responder;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  dbgAddrA;
    logic [31:0] dbgRdataA;
    logic [1:0]  dbgAddrB;
    logic [31:0] dbgRdataB;

    dmem_responder_if ifA ();
    dmem_responder_if ifB ();

    dmem_responder #(.DEPTH(256), .WAIT_STATES(2), .DATA_WIDTH(32)) dutA (
        .clk(clk), .reset(reset), .bus(ifA.slave),
        .dbg_addr(dbgAddrA), .dbg_rdata(dbgRdataA)
    );

    dmem_responder #(.DEPTH(4), .WAIT_STATES(0), .DATA_WIDTH(32)) dutB (
        .clk(clk), .reset(reset), .bus(ifB.slave),
        .dbg_addr(dbgAddrB), .dbg_rdata(dbgRdataB)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issueA(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int waited);
        waited = 0;
        ifA.req_write = wr;
        ifA.req_addr  = addr;
        ifA.req_wdata = wdata;
        ifA.req_valid = 1'b1;
        while (ifA.req_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("A_accept_ready", 32'(ifA.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ifA.req_valid = 1'b0;
    endtask

    task automatic completeA(input int hold, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (ifA.resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : {33{1'bx}};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(ifA.resp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, ifA.resp_rdata, e.rdata);
            chk({tag, "_hold_req_ready"}, 32'(ifA.req_ready), 32'd0);
        end
        chk({tag, "_rdata"}, ifA.resp_rdata, e.rdata);
        chk({tag, "_error"}, 32'(ifA.resp_error), 32'(e.err));
        ifA.resp_ready = 1'b1;
        @(negedge clk);
        ifA.resp_ready = 1'b0;
        chk({tag, "_drop_valid"}, 32'(ifA.resp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(ifA.req_ready), 32'd1);
    endtask

    task automatic sendA(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expR, input logic expE, input int hold,
                         input string tag);
        int w;
        sb.push_back('{rdata: expR, err: expE});
        issueA(wr, addr, wdata, w);
        completeA(hold, tag);
    endtask

    logic        itemWr  [5];
    logic [31:0] itemAddr[5];
    logic [31:0] itemData[5];
    logic [31:0] itemExpR[5];
    logic        itemExpE[5];

    initial begin
        int   waited;
        int   n;
        int   idx;
        int   got;
        int   guard;
        int   lastAcc;
        int   prevAcc;
        exp_t e;

        itemWr[0] = MEM_WRITE; itemAddr[0] = 32'h0;  itemData[0] = 32'hA0A0_0001; itemExpR[0] = 32'h0;          itemExpE[0] = 1'b0;
        itemWr[1] = MEM_WRITE; itemAddr[1] = 32'hC;  itemData[1] = 32'hC0C0_000C; itemExpR[1] = 32'h0;          itemExpE[1] = 1'b0;
        itemWr[2] = MEM_READ;  itemAddr[2] = 32'h0;  itemData[2] = 32'h0;         itemExpR[2] = 32'hA0A0_0001; itemExpE[2] = 1'b0;
        itemWr[3] = MEM_READ;  itemAddr[3] = 32'hC;  itemData[3] = 32'h0;         itemExpR[3] = 32'hC0C0_000C; itemExpE[3] = 1'b0;
        itemWr[4] = MEM_WRITE; itemAddr[4] = 32'h10; itemData[4] = 32'hBAD0_BAD0; itemExpR[4] = 32'h0;          itemExpE[4] = 1'b1;

        reset = 1'b1;
        ifA.req_valid = 1'b0; ifA.req_write = 1'b0; ifA.req_addr = 32'h0; ifA.req_wdata = 32'h0;
        ifA.resp_ready = 1'b0;
        ifB.req_valid = 1'b0; ifB.req_write = 1'b0; ifB.req_addr = 32'h0; ifB.req_wdata = 32'h0;
        ifB.resp_ready = 1'b0;
        dbgAddrA = 8'd0;
        dbgAddrB = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(ifA.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(ifA.resp_valid), 32'd0);
        chk("rst_resp_rdata", ifA.resp_rdata, 32'h0);
        chk("rst_resp_error", 32'(ifA.resp_error), 32'd0);
        chk("rst_B_req_ready", 32'(ifB.req_ready), 32'd1);
        reset = 1'b0;

        // Store, first-edge accept, then peek
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        issueA(MEM_WRITE, 32'h10, 32'hDEAD_BEEF, waited);
        chk("st10_first_edge_accept", 32'(waited), 32'd0);
        completeA(0, "st10");
        dbgAddrA = 8'd4;
        #1 chk("st10_dbg", dbgRdataA, 32'hDEAD_BEEF);

        sendA(MEM_READ, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, "ld10");

        sendA(MEM_WRITE, 32'h13, 32'h1111_1111, 32'h0, 1'b1, 0, "st_misaligned");
        sendA(MEM_WRITE, 32'h400, 32'h2222_2222, 32'h0, 1'b1, 0, "st_oob");
        #1 chk("err_dbg4_unchanged", dbgRdataA, 32'hDEAD_BEEF);

        // Reset on the counter=0 edge cancels the store
        sendA(MEM_WRITE, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 0, "preload20");
        issueA(MEM_WRITE, 32'h20, 32'h1234_5678, waited);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstbusy_req_ready", 32'(ifA.req_ready), 32'd1);
        chk("rstbusy_resp_valid", 32'(ifA.resp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstbusy_no_resp", 32'(ifA.resp_valid), 32'd0);
        end
        dbgAddrA = 8'd8;
        #1 chk("rstbusy_dbg8", dbgRdataA, 32'hCAFE_F00D);

        // Reset while presenting a response
        issueA(MEM_READ, 32'h10, 32'h0, waited);
        n = 0;
        while (ifA.resp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rstresp_reached", 32'(ifA.resp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstresp_valid_low", 32'(ifA.resp_valid), 32'd0);
        chk("rstresp_rdata_clr", ifA.resp_rdata, 32'h0);
        sendA(MEM_READ, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "ld_after_rst");

        // Instance B: zero wait states, resp_ready tied high
        ifB.resp_ready = 1'b1;
        idx = 0; got = 0; guard = 0; lastAcc = 0; prevAcc = -1;
        while (got < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (ifB.resp_valid === 1'b1) begin
                chk("B_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                e = (sb.size() > 0) ? sb.pop_front() : {33{1'bx}};
                chk("B_rdata", ifB.resp_rdata, e.rdata);
                chk("B_error", 32'(ifB.resp_error), 32'(e.err));
                chk("B_latency", 32'(cyc - lastAcc), 32'd1);
                got++;
            end
            if (idx < 5 && ifB.req_ready === 1'b1) begin
                ifB.req_write = itemWr[idx];
                ifB.req_addr  = itemAddr[idx];
                ifB.req_wdata = itemData[idx];
                ifB.req_valid = 1'b1;
                sb.push_back('{rdata: itemExpR[idx], err: itemExpE[idx]});
                lastAcc = cyc + 1;
                if (prevAcc >= 0) chk("B_accept_spacing", 32'(lastAcc - prevAcc), 32'd3);
                prevAcc = lastAcc;
                idx++;
            end else begin
                ifB.req_valid = 1'b0;
            end
        end
        chk("B_resp_count", 32'(got), 32'd5);
        dbgAddrB = 2'd0;
        #1 chk("B_oob_no_wrap", dbgRdataB, 32'hA0A0_0001);

        // Short req_valid pulse while busy is never answered
        @(negedge clk);
        chk("B_pulse_idle", 32'(ifB.req_ready), 32'd1);
        ifB.req_write = MEM_READ;
        ifB.req_addr  = 32'h0;
        ifB.req_valid = 1'b1;
        sb.push_back('{rdata: 32'hA0A0_0001, err: 1'b0});
        @(negedge clk);
        ifB.req_addr  = 32'hC;
        @(negedge clk);
        ifB.req_valid = 1'b0;
        chk("B_pulse_resp_valid", 32'(ifB.resp_valid), 32'd1);
        chk("B_pulse_sb_nonempty", 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : {33{1'bx}};
        chk("B_pulse_rdata", ifB.resp_rdata, e.rdata);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("B_pulse_ignored", 32'(ifB.resp_valid), 32'd0);
        end
        chk("B_final_ready", 32'(ifB.req_ready), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        dbgAddrB = 2'd3;
        #1 chk("B_dbg3", dbgRdataB, 32'hC0C0_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
